// File: rtl/imem_arbiter.sv
//==============================================================================
// Module   : imem_arbiter
// Purpose  : Shares one single-port RAM between instruction fetch (IF) and the
//            memory stage (MEM); optional round-robin via IMEM_ARB_RR_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module imem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_sel,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_ack,
    output logic                ram_ce,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_sel,
    input  logic [DATA_W-1:0]   ram_rdata,
    input  logic                ram_ready,
    output logic                bus_err
);

    localparam int                 c_cnt_w   = $clog2(TIMEOUT + 2);
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_if_vld;
    logic               w_mem_vld;
    logic               w_pick_mem;
    logic               w_pick_if;
    logic               w_timeout;
    logic               w_done;

    // A requester whose ack is on the bus this cycle is not re-granted yet.
    assign w_if_vld  = if_req  & ~if_ack;
    assign w_mem_vld = mem_req & ~mem_ack;

`ifdef IMEM_ARB_RR_EN
    logic r_last_mem;

    assign w_pick_mem = w_mem_vld & (~w_if_vld | ~r_last_mem);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_mem <= 1'b0;
        end else if (w_done) begin
            r_last_mem <= (r_state == GNT_MEM);
        end
    end
`else
    assign w_pick_mem = w_mem_vld;
`endif

    assign w_pick_if = w_if_vld & ~w_pick_mem;

    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign w_timeout = (r_state != IDLE) & ~ram_ready & (r_cnt == c_to_last);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign w_done = (r_state != IDLE) & (ram_ready | w_timeout);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_pick_mem) begin
                    w_state_nxt = GNT_MEM;
                end else if (w_pick_if) begin
                    w_state_nxt = GNT_IF;
                end
            end
            GNT_IF, GNT_MEM: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_sel   <= '0;
            if_ack    <= 1'b0;
            if_rdata  <= '0;
            mem_ack   <= 1'b0;
            mem_rdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            bus_err <= 1'b0;
            if (r_state == IDLE) begin
                r_cnt <= '0;
                if (w_pick_mem) begin
                    ram_ce    <= 1'b1;
                    ram_we    <= mem_we;
                    ram_addr  <= mem_addr;
                    ram_wdata <= mem_wdata;
                    ram_sel   <= mem_sel;
                end else if (w_pick_if) begin
                    ram_ce    <= 1'b1;
                    ram_we    <= 1'b0;
                    ram_addr  <= if_addr;
                    ram_wdata <= '0;
                    ram_sel   <= '1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (w_done) begin
                    ram_ce  <= 1'b0;
                    ram_we  <= 1'b0;
                    bus_err <= w_timeout;
                    if (r_state == GNT_IF) begin
                        if_ack   <= 1'b1;
                        if_rdata <= w_timeout ? '0 : ram_rdata;
                    end else begin
                        mem_ack   <= 1'b1;
                        mem_rdata <= (w_timeout | ram_we) ? '0 : ram_rdata;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
